// File: rtl/master_wr_back_drain_pkg.sv
// ---------------------------------------------------------------------------
// master_wr_back_pkg
// Shared definitions for the write-response back-path drain: packed word
// field positions, BRESP codes and the word parity helper.
// Packed word layout (19 bits):
//   [18:11] BID, [10:3] BUSER, [2:1] BRESP, [0] even parity over [18:1]
// ---------------------------------------------------------------------------
package master_wr_back_pkg;

  localparam int WB_WORD_WIDTH = 19;
  localparam int WB_ID_LSB     = 11;
  localparam int WB_USER_LSB   = 3;
  localparam int WB_RESP_LSB   = 1;
  localparam int WB_PAR_BIT    = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  // The parity bit makes the XOR of the whole word zero, so a word is good
  // exactly when the reduction XOR over all 19 bits is 0.
  function automatic logic wbParityOk(input logic [WB_WORD_WIDTH-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/master_wr_back_drain_if.sv
// ---------------------------------------------------------------------------
// master_wr_back_drain_if
// Bundles the back-FIFO read port and the AXI4 B channel seen by the drain.
//   fifo_rd_en    : pop request to the FIFO (driven by the drain)
//   fifo_rd_data  : packed response word, valid the cycle after fifo_rd_en
//   fifo_rd_empty : FIFO empty flag
//   b_id/b_user/b_resp/b_valid : B channel towards the master
//   b_ready       : master accepts the response
// Modports: master = drain side, slave = FIFO/master environment side.
// ---------------------------------------------------------------------------
interface master_wr_back_drain_if
  import master_wr_back_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8
);

  logic                     fifo_rd_en;
  logic [WB_WORD_WIDTH-1:0] fifo_rd_data;
  logic                     fifo_rd_empty;
  logic [ID_WIDTH-1:0]      b_id;
  logic [USER_WIDTH-1:0]    b_user;
  logic [1:0]               b_resp;
  logic                     b_valid;
  logic                     b_ready;

  modport master (
    output fifo_rd_en, b_id, b_user, b_resp, b_valid,
    input  fifo_rd_data, fifo_rd_empty, b_ready
  );

  modport slave (
    input  fifo_rd_en, b_id, b_user, b_resp, b_valid,
    output fifo_rd_data, fifo_rd_empty, b_ready
  );

endinterface

// File: rtl/master_wr_back_drain_skid2.sv
// ---------------------------------------------------------------------------
// master_wr_back_skid2
// Generic 2-entry FIFO-ordered buffer. Entry 0 is always the head.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i into the tail this cycle
//   push_data_i  : data to store
//   pop_i        : remove the head this cycle (ignored while empty)
//   head_o       : current head entry
//   occ_o        : number of stored entries, 0..2
// Push and pop may happen in the same cycle. The caller guarantees no push
// while full without a simultaneous pop.
// ---------------------------------------------------------------------------
module master_wr_back_skid2 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;
  logic             writeSecond;

  assign pop    = pop_i && (occ_q != 2'd0);
  assign head_o = entry0_q;
  assign occ_o  = occ_q;

  // The tail slot for a push is the occupancy left after this cycle's pop:
  // slot 1 when one entry survives, slot 0 otherwise.
  assign writeSecond = ((occ_q == 2'd1) && !pop) || (occ_q == 2'd2);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    if (pop && (occ_q == 2'd2)) begin
      entry0_d = entry1_q;
    end
    if (push_i) begin
      if (writeSecond) begin
        entry1_d = push_data_i;
      end else begin
        entry0_d = push_data_i;
      end
    end
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/master_wr_back_drain.sv
// ---------------------------------------------------------------------------
// master_wr_back_drain
// Read-side consumer of the write-response back FIFO. Pops packed words,
// checks parity (forcing SLVERR on failure) and presents them as an AXI4
// B channel through a 2-entry buffer, one response per cycle at full rate.
//   clk, rst     : FIFO read clock, synchronous active-high reset
//   bus          : FIFO read port + B channel (master modport)
//   resp_cnt     : completed B handshakes, wraps
//   par_err_cnt  : parity failures, saturates at all-ones
//   par_err      : one-cycle pulse per parity failure
// ---------------------------------------------------------------------------
module master_wr_back_drain
  import master_wr_back_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  master_wr_back_drain_if.master bus,
  output logic [CNT_WIDTH-1:0] resp_cnt,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic                 par_err
);

  localparam int ENTRY_W = ID_WIDTH + USER_WIDTH + 2;

  logic                 pend_q, pend_d;
  logic                 parErr_q, parErr_d;
  logic [CNT_WIDTH-1:0] respCnt_q, respCnt_d;
  logic [CNT_WIDTH-1:0] parErrCnt_q, parErrCnt_d;
  logic [1:0]           occ;
  logic [ENTRY_W-1:0]   head;
  logic [ENTRY_W-1:0]   captEntry;
  logic [1:0]           captResp;
  logic [2:0]           credit;
  logic                 handshake;
  logic                 parityOk;
  logic                 captErr;

  assign bus.b_valid = (occ != 2'd0);
  assign handshake   = bus.b_valid & bus.b_ready;

  // Free slots counting the word already in flight; a handshake this cycle
  // frees the head in time for a word requested now. occ + pend never
  // exceeds 2, so this never goes negative.
  assign credit = 3'd2 - {1'b0, occ} - {2'b00, pend_q} + {2'b00, handshake};

  assign bus.fifo_rd_en = !rst && !bus.fifo_rd_empty && (credit != 3'd0);

  // Captured word: a parity failure replaces BRESP with SLVERR, ID and USER
  // pass through untouched.
  assign parityOk  = wbParityOk(bus.fifo_rd_data);
  assign captResp  = parityOk ? bus.fifo_rd_data[WB_RESP_LSB +: 2] : RESP_SLVERR;
  assign captEntry = {bus.fifo_rd_data[WB_ID_LSB +: ID_WIDTH],
                      bus.fifo_rd_data[WB_USER_LSB +: USER_WIDTH],
                      captResp};
  assign captErr   = pend_q && !parityOk;

  master_wr_back_skid2 #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pend_q),
    .push_data_i (captEntry),
    .pop_i       (handshake),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign bus.b_id    = head[ENTRY_W-1 -: ID_WIDTH];
  assign bus.b_user  = head[2 +: USER_WIDTH];
  assign bus.b_resp  = head[1:0];
  assign resp_cnt    = respCnt_q;
  assign par_err_cnt = parErrCnt_q;
  assign par_err     = parErr_q;

  // Next state for the in-flight flag, error pulse and statistics counters.
  always_comb begin
    pend_d      = bus.fifo_rd_en;
    parErr_d    = captErr;
    respCnt_d   = respCnt_q;
    parErrCnt_d = parErrCnt_q;
    if (handshake) begin
      respCnt_d = respCnt_q + 1'b1;
    end
    if (captErr && (parErrCnt_q != {CNT_WIDTH{1'b1}})) begin
      parErrCnt_d = parErrCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      parErr_q    <= 1'b0;
      respCnt_q   <= '0;
      parErrCnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      parErr_q    <= parErr_d;
      respCnt_q   <= respCnt_d;
      parErrCnt_q <= parErrCnt_d;
    end
  end

  occPendBound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ} + {2'b00, pend_q}) <= 3'd2));

  noReadWhenEmpty: assert property (@(posedge clk)
    (bus.fifo_rd_en |-> !bus.fifo_rd_empty));

endmodule

// File: tb/tb_master_wr_back_drain.sv
// ---------------------------------------------------------------------------
// tb_master_wr_back_drain
// Directed and random checks of the write-response drain against a simple
// FIFO model and hand-computed expected responses.
// ---------------------------------------------------------------------------
module tb_master_wr_back_drain;
  import master_wr_back_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] respCnt;
  logic [15:0] parErrCnt;
  logic        parErr;

  int testsRun    = 0;
  int testsFailed = 0;

  // FIFO model: the main thread owns the write side, the FIFO process owns
  // the read side.
  logic [18:0] fifoMem [0:2047];
  int          wrPtr = 0;
  int          rdPtr = 0;
  logic        doPop;

  // Monitor-owned records.
  logic [17:0] gotQ [$];
  int          rdEnPulses     = 0;
  int          rdEnWhileEmpty = 0;
  int          parErrPulses   = 0;

  logic [17:0] expQ [$];

  always #5 clk = ~clk;

  master_wr_back_drain_if #(.ID_WIDTH(8), .USER_WIDTH(8)) bus ();

  master_wr_back_drain #(
    .ID_WIDTH   (8),
    .USER_WIDTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .resp_cnt    (respCnt),
    .par_err_cnt (parErrCnt),
    .par_err     (parErr)
  );

  // FIFO read side: pop decided at the edge, data and empty updated shortly
  // after so they are stable for the next edge. Reset flushes the FIFO.
  always @(posedge clk) begin
    doPop = bus.fifo_rd_en;
    #2;
    if (rst) begin
      rdPtr = wrPtr;
    end else if (doPop && (rdPtr != wrPtr)) begin
      bus.fifo_rd_data = fifoMem[rdPtr % 2048];
      rdPtr++;
    end
    bus.fifo_rd_empty = (rdPtr == wrPtr);
  end

  // Observe handshakes, read pulses and error pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.b_valid && bus.b_ready) gotQ.push_back({bus.b_id, bus.b_user, bus.b_resp});
      if (bus.fifo_rd_en) rdEnPulses++;
      if (bus.fifo_rd_en && bus.fifo_rd_empty) rdEnWhileEmpty++;
      if (parErr) parErrPulses++;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [18:0] makeWord(input logic [7:0] id, input logic [7:0] user,
                                           input logic [1:0] resp, input logic bad);
    logic [18:0] w;
    w    = {id, user, resp, 1'b0};
    w[0] = ^w[18:1];
    if (bad) w[0] = ~w[0];
    return w;
  endfunction

  task automatic pushWord(input logic [18:0] w);
    fifoMem[wrPtr % 2048] = w;
    wrPtr++;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.b_ready = 1'b1;
    pushWord(makeWord(8'h12, 8'h34, 2'b00, 1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    testsRun++;
    if (bus.fifo_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    testsRun++;
    if (bus.b_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_b_valid: got %b want 0", bus.b_valid); end
    testsRun++;
    if (bus.b_id !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_b_id: got %h want 00", bus.b_id); end
    testsRun++;
    if (bus.b_user !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_b_user: got %h want 00", bus.b_user); end
    testsRun++;
    if (bus.b_resp !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_b_resp: got %b want 00", bus.b_resp); end
    testsRun++;
    if (respCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_resp_cnt: got %0d want 0", respCnt); end
    testsRun++;
    if (parErrCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_par_err_cnt: got %0d want 0", parErrCnt); end
    testsRun++;
    if (parErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_par_err: got %b want 0", parErr); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.b_ready = 1'b0;
  endtask

  task automatic test_single();
    int p0;
    doReset();
    @(posedge clk); #1;
    p0          = rdEnPulses;
    bus.b_ready = 1'b1;
    pushWord(makeWord(8'h5A, 8'h3C, 2'b00, 1'b0));
    @(negedge clk);
    testsRun++;
    if (bus.fifo_rd_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_rd_en: got %b want 1", bus.fifo_rd_en); end
    @(negedge clk);
    testsRun++;
    if (bus.b_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_early_valid: got %b want 0", bus.b_valid); end
    @(negedge clk);
    testsRun++;
    if (bus.b_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_valid: got %b want 1", bus.b_valid); end
    testsRun++;
    if (bus.b_id !== 8'h5A) begin testsFailed++; $display("[TB] FAIL single_b_id: got %h want 5a", bus.b_id); end
    testsRun++;
    if (bus.b_user !== 8'h3C) begin testsFailed++; $display("[TB] FAIL single_b_user: got %h want 3c", bus.b_user); end
    testsRun++;
    if (bus.b_resp !== 2'b00) begin testsFailed++; $display("[TB] FAIL single_b_resp: got %b want 00", bus.b_resp); end
    @(negedge clk);
    testsRun++;
    if (bus.b_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_valid_drop: got %b want 0", bus.b_valid); end
    testsRun++;
    if (respCnt !== 16'd1) begin testsFailed++; $display("[TB] FAIL single_resp_cnt: got %0d want 1", respCnt); end
    testsRun++;
    if ((rdEnPulses - p0) !== 1) begin testsFailed++; $display("[TB] FAIL single_rd_pulses: got %0d want 1", rdEnPulses - p0); end
  endtask

  task automatic test_stream();
    int base;
    int c;
    int validCnt;
    int bad;
    doReset();
    @(posedge clk); #1;
    base        = gotQ.size();
    bus.b_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pushWord(makeWord(8'(i), 8'(~i), 2'(i), 1'b0));
      expQ.push_back({8'(i), 8'(~i), 2'(i)});
    end
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.b_valid && c < 10);
    testsRun++;
    if (bus.b_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_start: got b_valid %b want 1 within 10 cycles", bus.b_valid); end
    validCnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.b_valid) validCnt++;
      @(negedge clk);
    end
    testsRun++;
    if (validCnt !== 64) begin testsFailed++; $display("[TB] FAIL stream_consecutive: got %0d valid cycles want 64", validCnt); end
    testsRun++;
    if (bus.b_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_end_valid: got %b want 0", bus.b_valid); end
    testsRun++;
    if (respCnt !== 16'd64) begin testsFailed++; $display("[TB] FAIL stream_resp_cnt: got %0d want 64", respCnt); end
    @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < 64; i++) begin
      if ((base + i >= gotQ.size()) || (gotQ[base + i] !== expQ[i])) begin bad = i; break; end
    end
    testsRun++;
    if (bad >= 0) begin testsFailed++; $display("[TB] FAIL stream_order: first bad index %0d want %h", bad, expQ[bad]); end
  endtask

  task automatic test_backpressure();
    int base;
    int p0;
    int changes;
    int hs;
    int c;
    int bad;
    logic seen;
    logic [17:0] headRef;
    doReset();
    @(posedge clk); #1;
    base        = gotQ.size();
    p0          = rdEnPulses;
    bus.b_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pushWord(makeWord(8'hA0 + 8'(i), 8'h10 + 8'(i), 2'b01, 1'b0));
      expQ.push_back({8'hA0 + 8'(i), 8'h10 + 8'(i), 2'b01});
    end
    seen    = 1'b0;
    changes = 0;
    headRef = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (seen && ({bus.b_id, bus.b_user, bus.b_resp} !== headRef)) changes++;
      if (bus.b_valid && !seen) begin seen = 1'b1; headRef = {bus.b_id, bus.b_user, bus.b_resp}; end
    end
    testsRun++;
    if ((rdEnPulses - p0) !== 2) begin testsFailed++; $display("[TB] FAIL bp_rd_pulses: got %0d want 2", rdEnPulses - p0); end
    testsRun++;
    if (changes !== 0) begin testsFailed++; $display("[TB] FAIL bp_stable: got %0d head changes want 0", changes); end
    testsRun++;
    if (bus.b_id !== 8'hA0) begin testsFailed++; $display("[TB] FAIL bp_head_id: got %h want a0", bus.b_id); end
    @(posedge clk); #1;
    bus.b_ready = 1'b1;
    @(negedge clk);
    testsRun++;
    if (bus.fifo_rd_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release_rd_en: got %b want 1", bus.fifo_rd_en); end
    hs = 0;
    c  = 0;
    while (1) begin
      c++;
      if (bus.b_valid && bus.b_ready) hs++;
      if (hs >= 10 || c >= 40) break;
      @(negedge clk);
    end
    testsRun++;
    if (c !== 10 || hs !== 10) begin testsFailed++; $display("[TB] FAIL bp_release_gapless: got %0d handshakes in %0d cycles want 10 in 10", hs, c); end
    @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < 10; i++) begin
      if ((base + i >= gotQ.size()) || (gotQ[base + i] !== expQ[i])) begin bad = i; break; end
    end
    testsRun++;
    if (bad >= 0) begin testsFailed++; $display("[TB] FAIL bp_order: first bad index %0d want %h", bad, expQ[bad]); end
  endtask

  task automatic test_parity();
    int base;
    int pe0;
    doReset();
    @(posedge clk); #1;
    base        = gotQ.size();
    pe0         = parErrPulses;
    bus.b_ready = 1'b1;
    pushWord(makeWord(8'h11, 8'hAA, 2'b00, 1'b0));
    pushWord(makeWord(8'h22, 8'h55, 2'b01, 1'b1));
    pushWord(makeWord(8'h33, 8'h0F, 2'b01, 1'b0));
    expQ.push_back({8'h11, 8'hAA, 2'b00});
    expQ.push_back({8'h22, 8'h55, 2'b10});
    expQ.push_back({8'h33, 8'h0F, 2'b01});
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if ((base + i >= gotQ.size()) || (gotQ[base + i] !== expQ[i])) begin
        testsFailed++;
        $display("[TB] FAIL parity_word%0d: got %h want %h", i, (base + i < gotQ.size()) ? gotQ[base + i] : 18'h0, expQ[i]);
      end
    end
    testsRun++;
    if ((parErrPulses - pe0) !== 1) begin testsFailed++; $display("[TB] FAIL parity_pulse: got %0d pulse cycles want 1", parErrPulses - pe0); end
    testsRun++;
    if (parErrCnt !== 16'd1) begin testsFailed++; $display("[TB] FAIL parity_cnt: got %0d want 1", parErrCnt); end
    testsRun++;
    if (respCnt !== 16'd3) begin testsFailed++; $display("[TB] FAIL parity_resp_cnt: got %0d want 3", respCnt); end
  endtask

  task automatic test_reset_mid();
    int base;
    int validCycles;
    doReset();
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushWord(makeWord(8'hC0 + 8'(i), 8'h77, 2'b00, 1'b0));
    repeat (6) @(negedge clk);
    testsRun++;
    if (bus.b_valid !== 1'b1 || bus.fifo_rd_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_full: got b_valid %b rd_en %b want 1 0", bus.b_valid, bus.fifo_rd_en);
    end
    @(posedge clk); #1;
    bus.b_ready = 1'b1;
    @(negedge clk);
    testsRun++;
    if (bus.fifo_rd_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_rd_en: got %b want 1", bus.fifo_rd_en); end
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.b_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (bus.b_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_valid: got %b want 0", bus.b_valid); end
    testsRun++;
    if (respCnt !== 16'd0 || parErrCnt !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL mid_counters: got resp_cnt %0d par_err_cnt %0d want 0 0", respCnt, parErrCnt);
    end
    validCycles = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.b_valid) validCycles++;
    end
    testsRun++;
    if (validCycles !== 0) begin testsFailed++; $display("[TB] FAIL mid_late_word: got %0d valid cycles want 0", validCycles); end
    @(posedge clk); #1;
    base        = gotQ.size();
    bus.b_ready = 1'b1;
    pushWord(makeWord(8'hE7, 8'h81, 2'b11, 1'b0));
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    testsRun++;
    if ((gotQ.size() !== base + 1) || (gotQ[base] !== {8'hE7, 8'h81, 2'b11})) begin
      testsFailed++;
      $display("[TB] FAIL mid_fresh_word: got %0d words, first %h want 1 word e7812 pattern %h",
               gotQ.size() - base, (gotQ.size() > base) ? gotQ[base] : 18'h0, {8'hE7, 8'h81, 2'b11});
    end
    testsRun++;
    if (respCnt !== 16'd1) begin testsFailed++; $display("[TB] FAIL mid_fresh_cnt: got %0d want 1", respCnt); end
  endtask

  task automatic test_random();
    int base;
    int pe0;
    int pushed;
    int badCnt;
    int cyc;
    int bad;
    logic [7:0] id;
    logic [7:0] user;
    logic [1:0] resp;
    logic       perr;
    doReset();
    @(posedge clk); #1;
    base   = gotQ.size();
    pe0    = parErrPulses;
    pushed = 0;
    badCnt = 0;
    cyc    = 0;
    while ((gotQ.size() - base) < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      bus.b_ready = ($urandom_range(0, 9) < 3);
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        id   = 8'($urandom);
        user = 8'($urandom);
        resp = 2'($urandom);
        perr = ($urandom_range(0, 9) == 0);
        pushWord(makeWord(id, user, resp, perr));
        expQ.push_back({id, user, perr ? 2'b10 : resp});
        if (perr) badCnt++;
        pushed++;
      end
    end
    bus.b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if ((gotQ.size() - base) !== 1000) begin testsFailed++; $display("[TB] FAIL rand_count: got %0d responses want 1000", gotQ.size() - base); end
    bad = -1;
    for (int i = 0; i < 1000 && (base + i) < gotQ.size(); i++) begin
      if (gotQ[base + i] !== expQ[i]) begin bad = i; break; end
    end
    testsRun++;
    if (bad >= 0) begin testsFailed++; $display("[TB] FAIL rand_scoreboard: index %0d got %h want %h", bad, gotQ[base + bad], expQ[bad]); end
    testsRun++;
    if (rdEnWhileEmpty !== 0) begin testsFailed++; $display("[TB] FAIL rand_rd_when_empty: got %0d cycles want 0", rdEnWhileEmpty); end
    testsRun++;
    if (respCnt !== 16'd1000) begin testsFailed++; $display("[TB] FAIL rand_resp_cnt: got %0d want 1000", respCnt); end
    testsRun++;
    if (parErrCnt !== 16'(badCnt)) begin testsFailed++; $display("[TB] FAIL rand_par_err_cnt: got %0d want %0d", parErrCnt, badCnt); end
    testsRun++;
    if ((parErrPulses - pe0) !== badCnt) begin testsFailed++; $display("[TB] FAIL rand_par_err_pulses: got %0d want %0d", parErrPulses - pe0, badCnt); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.b_ready  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_parity();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
